// File: rtl/fem_ttc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fem_ttc_pkg : shared widths, defaults and FSM encoding for TTC gen |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fem_ttc_pkg;

  localparam int ORBIT_LEN_DEF = 3564;
  localparam int MIN_GAP_DEF   = 3;
  localparam int BX_W          = 12;
  localparam int L1A_CNT_W     = 24;
  localparam int BURST_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RSYNC = 2'd2
  } state_t;

  // A burst can never space its L1As closer than the global gap rule allows.
  function automatic logic [BURST_W-1:0] eff_period(input logic [BURST_W-1:0] period,
                                                    input int min_gap);
    if (int'(period) < min_gap) return BURST_W'(min_gap);
    return period;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fem_ttc_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fem_ttc_gen_if : request inputs and fast-command outputs           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fem_ttc_gen_if;
  import fem_ttc_pkg::*;

  logic                 enable;
  logic                 l1a_req;
  logic                 match_req;
  logic                 burst_start;
  logic [BURST_W-1:0]   burst_cnt;
  logic [BURST_W-1:0]   burst_period;
  logic                 resync_req;

  logic                 l1a;
  logic                 l1a_match;
  logic                 resync;
  logic                 bc0;
  logic [BX_W-1:0]      bx_cnt;
  logic [L1A_CNT_W-1:0] l1a_cnt;
  logic                 busy;

  modport master (
    output enable, l1a_req, match_req, burst_start, burst_cnt, burst_period, resync_req,
    input  l1a, l1a_match, resync, bc0, bx_cnt, l1a_cnt, busy
  );

  modport slave (
    input  enable, l1a_req, match_req, burst_start, burst_cnt, burst_period, resync_req,
    output l1a, l1a_match, resync, bc0, bx_cnt, l1a_cnt, busy
  );

endinterface
`default_nettype wire

// File: rtl/bx_orbit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bx_orbit_counter : BX position in orbit with wrap and BC0 decode   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bx_orbit_counter
  import fem_ttc_pkg::*;
#(
  parameter int ORBIT_LEN = ORBIT_LEN_DEF
) (
  input  wire             clk40,
  input  wire             rst_n,
  input  wire             en,
  input  wire             clr,
  output logic [BX_W-1:0] bx_cnt,
  output logic            bc0
);

  localparam logic [BX_W-1:0] c_last_bx = BX_W'(ORBIT_LEN - 1);

  logic [BX_W-1:0] bx_q, bx_d;
  logic            bc0_q, bc0_d;

  always_comb begin
    bx_d = bx_q;
    if (clr) begin
      bx_d = '0;
    end else if (en) begin
      bx_d = (bx_q == c_last_bx) ? '0 : bx_q + 1'b1;
    end
    // BC0 is registered alongside the count so both change on the same edge.
    bc0_d = en && (bx_d == '0);
  end

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      bx_q  <= '0;
      bc0_q <= 1'b0;
    end else begin
      bx_q  <= bx_d;
      bc0_q <= bc0_d;
    end
  end

  assign bx_cnt = bx_q;
  assign bc0    = bc0_q;

endmodule
`default_nettype wire

// File: rtl/fem_ttc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fem_ttc_gen : L1A / burst / resync fast-command generator for FEM  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fem_ttc_gen
  import fem_ttc_pkg::*;
#(
  parameter int ORBIT_LEN = ORBIT_LEN_DEF,
  parameter int MIN_GAP   = MIN_GAP_DEF
) (
  input  wire          clk40,
  input  wire          rst_n,
  fem_ttc_gen_if.slave bus
);

  localparam int                 c_gap_w    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(MIN_GAP - 1);

  state_t               state_q, state_d;
  logic                 pend_q, pend_d, pend_match_q, pend_match_d;
  logic [BURST_W-1:0]   burst_rem_q, burst_rem_d, burst_per_q, burst_per_d;
  logic [BURST_W-1:0]   burst_tmr_q, burst_tmr_d;
  logic                 burst_match_q, burst_match_d;
  logic [c_gap_w-1:0]   gap_q, gap_d;
  logic                 l1a_q, l1a_d, l1a_match_q, l1a_match_d;
  logic                 resync_q, resync_d, busy_q, busy_d;
  logic [L1A_CNT_W-1:0] l1a_cnt_q, l1a_cnt_d;
  logic                 gap_ok, fire, fire_match, bx_clr;
  logic [BX_W-1:0]      bx_cnt;
  logic                 bc0;

  // gap_q counts the remaining cycles in which no new L1A may be scheduled.
  assign gap_ok = (gap_q == '0);

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_match_d  = pend_match_q;
    burst_rem_d   = burst_rem_q;
    burst_per_d   = burst_per_q;
    burst_tmr_d   = burst_tmr_q;
    burst_match_d = burst_match_q;
    gap_d         = gap_ok ? gap_q : gap_q - 1'b1;
    l1a_cnt_d     = l1a_cnt_q;
    fire          = 1'b0;
    fire_match    = 1'b0;
    resync_d      = 1'b0;
    bx_clr        = 1'b0;

    if (!bus.enable) begin
      state_d      = ST_IDLE;
      pend_d       = 1'b0;
      pend_match_d = 1'b0;
    end else if (bus.resync_req) begin
      state_d      = ST_RSYNC;
      pend_d       = 1'b0;
      pend_match_d = 1'b0;
      burst_rem_d  = '0;
      resync_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q && gap_ok) begin
            fire         = 1'b1;
            fire_match   = pend_match_q;
            pend_d       = 1'b0;
            pend_match_d = 1'b0;
          end else if (bus.l1a_req && !pend_q) begin
            if (gap_ok) begin
              fire       = 1'b1;
              fire_match = bus.match_req;
            end else begin
              pend_d       = 1'b1;
              pend_match_d = bus.match_req;
            end
          end
          if (bus.burst_start && (bus.burst_cnt != '0)) begin
            state_d       = ST_BURST;
            burst_rem_d   = bus.burst_cnt;
            burst_per_d   = eff_period(bus.burst_period, MIN_GAP);
            burst_tmr_d   = '0;
            burst_match_d = bus.match_req;
          end
        end
        ST_BURST: begin
          if ((burst_tmr_q == '0) && gap_ok) begin
            fire        = 1'b1;
            fire_match  = burst_match_q;
            burst_rem_d = burst_rem_q - 1'b1;
            burst_tmr_d = burst_per_q - 1'b1;
            if (burst_rem_q == BURST_W'(1)) state_d = ST_IDLE;
          end else if (burst_tmr_q != '0) begin
            burst_tmr_d = burst_tmr_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The cycle carrying RESYNC realigns the orbit and the trigger count.
    if (bus.enable && (state_q == ST_RSYNC)) begin
      bx_clr    = 1'b1;
      l1a_cnt_d = '0;
    end
    if (fire) begin
      l1a_cnt_d = l1a_cnt_q + 1'b1;
      gap_d     = c_gap_load;
    end
    l1a_d       = fire;
    l1a_match_d = fire && fire_match;
    busy_d      = (state_d != ST_IDLE) || pend_d;
  end

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pend_q        <= 1'b0;
      pend_match_q  <= 1'b0;
      burst_rem_q   <= '0;
      burst_per_q   <= '0;
      burst_tmr_q   <= '0;
      burst_match_q <= 1'b0;
      gap_q         <= '0;
      l1a_q         <= 1'b0;
      l1a_match_q   <= 1'b0;
      resync_q      <= 1'b0;
      busy_q        <= 1'b0;
      l1a_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_match_q  <= pend_match_d;
      burst_rem_q   <= burst_rem_d;
      burst_per_q   <= burst_per_d;
      burst_tmr_q   <= burst_tmr_d;
      burst_match_q <= burst_match_d;
      gap_q         <= gap_d;
      l1a_q         <= l1a_d;
      l1a_match_q   <= l1a_match_d;
      resync_q      <= resync_d;
      busy_q        <= busy_d;
      l1a_cnt_q     <= l1a_cnt_d;
    end
  end

  bx_orbit_counter #(
    .ORBIT_LEN (ORBIT_LEN)
  ) u_bx_orbit_counter (
    .clk40  (clk40),
    .rst_n  (rst_n),
    .en     (bus.enable),
    .clr    (bx_clr),
    .bx_cnt (bx_cnt),
    .bc0    (bc0)
  );

  assign bus.l1a       = l1a_q;
  assign bus.l1a_match = l1a_match_q;
  assign bus.resync    = resync_q;
  assign bus.bc0       = bc0;
  assign bus.bx_cnt    = bx_cnt;
  assign bus.l1a_cnt   = l1a_cnt_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fem_ttc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fem_ttc_gen : directed scenarios plus random traffic vs model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fem_ttc_gen;
  import fem_ttc_pkg::*;

  localparam int ORBIT = 3564;
  localparam int GAP   = 3;

  logic clk40 = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   l1a_times[$];
  int   bc0_times[$];

  fem_ttc_gen_if bus ();

  fem_ttc_gen #(.ORBIT_LEN(ORBIT), .MIN_GAP(GAP)) dut (
    .clk40 (clk40),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #12.5 clk40 = ~clk40;

  // Reference model: absolute cycle numbers instead of timers.
  int m_bx, m_cnt, m_last, m_bleft, m_bnext, m_bper;
  bit m_pend, m_pmatch, m_bmatch, m_rsync;
  bit e_l1a, e_match, e_resync, e_bc0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = 0; m_cnt = 0; m_last = -1000; m_bleft = 0; m_bnext = 0; m_bper = 0;
    m_pend = 0; m_pmatch = 0; m_bmatch = 0; m_rsync = 0;
    e_l1a = 0; e_match = 0; e_resync = 0; e_bc0 = 0;
  endtask

  task automatic model_fire(input bit m);
    e_l1a   = 1;
    e_match = m;
    m_cnt   = (m_cnt + 1) % (1 << 24);
    m_last  = cyc;
  endtask

  // Computes expected outputs for cycle 'cyc' from inputs sampled at its start edge.
  task automatic model_step();
    e_l1a = 0; e_match = 0; e_resync = 0;
    if (!bus.enable) begin
      m_bleft = 0; m_pend = 0; m_rsync = 0; e_bc0 = 0;
      return;
    end
    if (m_rsync) begin m_bx = 0; m_cnt = 0; end
    else m_bx = (m_bx + 1) % ORBIT;
    e_bc0 = (m_bx == 0);
    if (bus.resync_req) begin
      e_resync = 1; m_bleft = 0; m_pend = 0; m_rsync = 1;
      return;
    end
    if (m_rsync) begin m_rsync = 0; return; end
    if (m_bleft > 0) begin
      if (cyc >= m_bnext && cyc >= m_last + GAP) begin
        model_fire(m_bmatch);
        m_bleft--;
        m_bnext = cyc + m_bper;
      end
      return;
    end
    if (m_pend && cyc >= m_last + GAP) begin
      model_fire(m_pmatch);
      m_pend = 0;
    end else if (bus.l1a_req && !m_pend) begin
      if (cyc >= m_last + GAP) model_fire(bus.match_req);
      else begin m_pend = 1; m_pmatch = bus.match_req; end
    end
    if (bus.burst_start && bus.burst_cnt != 0) begin
      m_bleft  = int'(bus.burst_cnt);
      m_bmatch = bus.match_req;
      m_bper   = (int'(bus.burst_period) < GAP) ? GAP : int'(bus.burst_period);
      m_bnext  = cyc + 1;
    end
  endtask

  task automatic compare_all();
    chk("l1a",       32'(bus.l1a),       32'(e_l1a));
    chk("l1a_match", 32'(bus.l1a_match), 32'(e_match));
    chk("resync",    32'(bus.resync),    32'(e_resync));
    chk("bc0",       32'(bus.bc0),       32'(e_bc0));
    chk("bx_cnt",    32'(bus.bx_cnt),    32'(m_bx));
    chk("l1a_cnt",   32'(bus.l1a_cnt),   32'(m_cnt));
    chk("busy",      32'(bus.busy),      32'(m_rsync || m_bleft > 0 || m_pend));
  endtask

  task automatic tick();
    @(posedge clk40);
    cyc++;
    if (rst_n) model_step();
    else model_reset();
    #1;
    compare_all();
    if (bus.l1a === 1'b1) l1a_times.push_back(cyc);
    if (bus.bc0 === 1'b1) bc0_times.push_back(cyc);
  endtask

  task automatic clear_reqs();
    bus.l1a_req = 0; bus.match_req = 0; bus.burst_start = 0; bus.resync_req = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_l1a"},   32'(bus.l1a),       32'd0);
    chk({tag, "_match"}, 32'(bus.l1a_match), 32'd0);
    chk({tag, "_rsync"}, 32'(bus.resync),    32'd0);
    chk({tag, "_bc0"},   32'(bus.bc0),       32'd0);
    chk({tag, "_bx"},    32'(bus.bx_cnt),    32'd0);
    chk({tag, "_cnt"},   32'(bus.l1a_cnt),   32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int k;
    int pulses;
    int n0;
    bus.enable = 0; bus.burst_cnt = 0; bus.burst_period = 0;
    clear_reqs();
    model_reset();
    #1 rst_n = 0;
    #3 chk_all_zero("reset");
    repeat (3) tick();
    @(negedge clk40);
    rst_n = 1;
    bus.enable = 1;

    // Two orbits: BC0 exactly once per ORBIT cycles.
    bc0_times.delete();
    repeat (7200) tick();
    chk("bc0_count", 32'(bc0_times.size()), 32'd2);
    if (bc0_times.size() == 2) chk("bc0_spacing", 32'(bc0_times[1] - bc0_times[0]), 32'd3564);

    // Back-to-back single requests: second is held by the gap rule.
    l1a_times.delete();
    bus.l1a_req = 1; bus.match_req = 1;
    tick();
    chk("single_l1a", 32'(bus.l1a), 32'd1);
    chk("single_match", 32'(bus.l1a_match), 32'd1);
    bus.match_req = 0;
    tick();
    clear_reqs();
    repeat (2) tick();
    chk("pend_l1a", 32'(bus.l1a), 32'd1);
    tick();
    chk("pair_count", 32'(l1a_times.size()), 32'd2);
    if (l1a_times.size() == 2) chk("pair_gap", 32'(l1a_times[1] - l1a_times[0]), 32'd3);
    chk("pair_l1a_cnt", 32'(bus.l1a_cnt), 32'd2);

    // Five-L1A burst with period below the gap.
    repeat (4) tick();
    l1a_times.delete();
    bus.burst_start = 1; bus.burst_cnt = 5; bus.burst_period = 1;
    tick();
    clear_reqs();
    repeat (20) tick();
    chk("burst5_count", 32'(l1a_times.size()), 32'd5);
    for (int i = 1; i < l1a_times.size(); i++)
      chk("burst5_spacing", 32'(l1a_times[i] - l1a_times[i-1]), 32'd3);
    chk("burst5_busy", 32'(bus.busy), 32'd0);

    // Resync landing on the third L1A of a ten-L1A burst.
    l1a_times.delete();
    bus.burst_start = 1; bus.burst_cnt = 10; bus.burst_period = 4;
    tick();
    clear_reqs();
    k = 0;
    while (l1a_times.size() < 2 && k < 40) begin tick(); k++; end
    chk("burst10_reach2", 32'(l1a_times.size()), 32'd2);
    repeat (3) tick();
    bus.resync_req = 1;
    tick();
    chk("rsync_no_l1a", 32'(bus.l1a), 32'd0);
    chk("rsync_pulse", 32'(bus.resync), 32'd1);
    clear_reqs();
    tick();
    chk("rsync_bx", 32'(bus.bx_cnt), 32'd0);
    chk("rsync_cnt", 32'(bus.l1a_cnt), 32'd0);
    chk("rsync_idle", 32'(bus.busy), 32'd0);

    // ENABLE low at BX 100 with a request pending.
    k = 0;
    while (bus.bx_cnt != 12'd98 && k < 4000) begin tick(); k++; end
    chk("reach_bx98", 32'(bus.bx_cnt), 32'd98);
    bus.l1a_req = 1;
    tick();
    tick();
    chk("dis_pend_busy", 32'(bus.busy), 32'd1);
    chk("dis_bx_start", 32'(bus.bx_cnt), 32'd100);
    bus.enable = 0;
    clear_reqs();
    n0 = l1a_times.size();
    pulses = 0;
    repeat (50) begin
      tick();
      pulses += int'(bus.l1a) + int'(bus.l1a_match) + int'(bus.resync) + int'(bus.bc0);
    end
    chk("dis_bx_hold", 32'(bus.bx_cnt), 32'd100);
    chk("dis_pulses", 32'(pulses), 32'd0);
    bus.enable = 1;
    repeat (10) tick();
    chk("dis_pend_dropped", 32'(l1a_times.size() - n0), 32'd0);

    // Asynchronous reset in the middle of a burst.
    l1a_times.delete();
    bus.burst_start = 1; bus.burst_cnt = 10; bus.burst_period = 5;
    tick();
    clear_reqs();
    k = 0;
    while (l1a_times.size() < 2 && k < 40) begin tick(); k++; end
    #5 rst_n = 0;
    model_reset();
    #1 chk_all_zero("midrst");
    repeat (2) tick();
    @(negedge clk40);
    rst_n = 1;
    bus.l1a_req = 1;
    tick();
    chk("post_rst_l1a", 32'(bus.l1a), 32'd1);
    clear_reqs();
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.enable       = ($urandom_range(0, 99) < 97);
      bus.l1a_req      = ($urandom_range(0, 99) < 25);
      bus.match_req    = 1'($urandom_range(0, 1));
      bus.burst_start  = ($urandom_range(0, 99) < 4);
      bus.burst_cnt    = 8'($urandom_range(0, 6));
      bus.burst_period = 8'($urandom_range(0, 6));
      bus.resync_req   = ($urandom_range(0, 99) < 2);
      tick();
    end
    clear_reqs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
